// File: rtl/led_show_pkg.sv
// Shared types and constants for the LED show controller: FSM encoding,
// mode codes and the initial/boundary patterns of each display mode.
package led_show_pkg;

  // Three-bit encoding leaves spare codes; the controller steers them back to SCAN_R.
  typedef enum logic [2:0] {
    ST_SCAN_R = 3'd0,
    ST_SCAN_L = 3'd1,
    ST_FILL   = 3'd2,
    ST_BLINK  = 3'd3
  } state_e;

  localparam logic [1:0] MODE_SCAN  = 2'd0;
  localparam logic [1:0] MODE_FILL  = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;

  localparam logic [7:0] SCAN_RED_INIT  = 8'hE0;
  localparam logic [7:0] SCAN_GRN_INIT  = 8'h00;
  localparam logic [7:0] FILL_RED_INIT  = 8'h80;
  localparam logic [7:0] BLINK_RED_INIT = 8'hFF;
  localparam logic [7:0] BLINK_GRN_INIT = 8'h00;

  localparam logic [7:0] SCAN_R_LAST  = 8'h07;
  localparam logic [7:0] SCAN_L_FIRST = 8'h0E;
  localparam logic [7:0] SCAN_L_LAST  = 8'hE0;
  localparam logic [7:0] SCAN_R_FIRST = 8'h70;
  localparam logic [7:0] FILL_FULL    = 8'hFF;

  function automatic logic [1:0] mode_of(state_e s);
    case (s)
      ST_FILL:  mode_of = MODE_FILL;
      ST_BLINK: mode_of = MODE_BLINK;
      default:  mode_of = MODE_SCAN;
    endcase
  endfunction

endpackage

// File: rtl/led_show_if.sv
// Control/display bundle of the LED show controller. The pause wire exists
// only when LED_SHOW_PAUSE_EN is defined.
interface led_show_if;
  logic       mode_next;
`ifdef LED_SHOW_PAUSE_EN
  logic       pause;
`endif
  logic [7:0] shift_red;
  logic [7:0] shift_green;
  logic       ctl_bit;
  logic [1:0] mode;
  logic       tick;

`ifdef LED_SHOW_PAUSE_EN
  modport master (output mode_next, pause,
                  input  shift_red, shift_green, ctl_bit, mode, tick);
  modport slave  (input  mode_next, pause,
                  output shift_red, shift_green, ctl_bit, mode, tick);
`else
  modport master (output mode_next,
                  input  shift_red, shift_green, ctl_bit, mode, tick);
  modport slave  (input  mode_next,
                  output shift_red, shift_green, ctl_bit, mode, tick);
`endif
endinterface

// File: rtl/led_tick_gen.sv
// Free-running prescaler: strobes tick while the count is all-ones.
// clr restarts the count; hold freezes it and masks the strobe.
module led_tick_gen #(
  parameter int DIV_W = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)        cnt_d = '0;
    else if (!hold) cnt_d = cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (&cnt_q) & ~hold;

endmodule

// File: rtl/led_show_ctrl.sv
// LED show controller: SCAN / FILL / BLINK patterns stepped by a prescaler.
// Optional pause input enabled by defining LED_SHOW_PAUSE_EN.
module led_show_ctrl
  import led_show_pkg::*;
#(
  parameter int DIV_W = 20
) (
  input  logic       clk,
  input  logic       reset,
  led_show_if.slave  bus
);

  state_e     state_q, state_d;
  logic [7:0] red_q, red_d;
  logic [7:0] green_q, green_d;
  logic [1:0] mode_q;
  logic       tick;
  logic       hold;

`ifdef LED_SHOW_PAUSE_EN
  assign hold = bus.pause;
`else
  assign hold = 1'b0;
`endif

  led_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.mode_next),
    .hold  (hold),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    red_d   = red_q;
    green_d = green_q;
    case (state_q)
      ST_SCAN_R, ST_SCAN_L, ST_FILL, ST_BLINK: begin
        // A mode change wins over a coincident step; the step is dropped.
        if (bus.mode_next) begin
          case (state_q)
            ST_FILL: begin
              state_d = ST_BLINK;
              red_d   = BLINK_RED_INIT;
              green_d = BLINK_GRN_INIT;
            end
            ST_BLINK: begin
              state_d = ST_SCAN_R;
              red_d   = SCAN_RED_INIT;
              green_d = SCAN_GRN_INIT;
            end
            default: begin
              state_d = ST_FILL;
              red_d   = FILL_RED_INIT;
              green_d = 8'h00;
            end
          endcase
        end else if (tick) begin
          case (state_q)
            ST_SCAN_R: begin
              if (red_q == SCAN_R_LAST) begin
                state_d = ST_SCAN_L;
                red_d   = 8'h00;
                green_d = SCAN_L_FIRST;
              end else begin
                red_d   = red_q >> 1;
              end
            end
            ST_SCAN_L: begin
              if (green_q == SCAN_L_LAST) begin
                state_d = ST_SCAN_R;
                red_d   = SCAN_R_FIRST;
                green_d = 8'h00;
              end else begin
                green_d = green_q << 1;
              end
            end
            ST_FILL: begin
              green_d = 8'h00;
              if (red_q == FILL_FULL) red_d = 8'h00;
              else                    red_d = {1'b1, red_q[7:1]};
            end
            default: begin
              red_d   = ~red_q;
              green_d = ~green_q;
            end
          endcase
        end
      end
      default: begin
        state_d = ST_SCAN_R;
        red_d   = SCAN_RED_INIT;
        green_d = SCAN_GRN_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_SCAN_R;
      red_q   <= SCAN_RED_INIT;
      green_q <= SCAN_GRN_INIT;
      mode_q  <= MODE_SCAN;
    end else begin
      state_q <= state_d;
      red_q   <= red_d;
      green_q <= green_d;
      mode_q  <= mode_of(state_d);
    end
  end

  assign bus.shift_red   = red_q;
  assign bus.shift_green = green_q;
  assign bus.mode        = mode_q;
  assign bus.tick        = tick;
  assign bus.ctl_bit     = 1'b1;

endmodule

// File: doc/led_show_ctrl.md
LED_SHOW_CTRL -- requirements
Module: led_show_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 20: prescaler width; one pattern step per 2^DIV_W clk cycles.
REQ-002 SHALL have port clk  input  1  system clock (10 MHz board clock).
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset on one clock, clk.
REQ-004 SHALL have port mode_next  input  1  single-cycle pulse, already synchronized; advances display mode.
REQ-005 SHALL have port pause  input  1  freeze request; present only when PAUSE_EN is defined.
REQ-006 SHALL have port shift_red  output  8  red LED row.
REQ-007 SHALL have port shift_green  output  8  green LED row.
REQ-008 SHALL have port ctl_bit  output  1  LED bank enable, constant 1.
REQ-009 SHALL have port mode  output  2  current mode: 0 SCAN, 1 FILL, 2 BLINK.
REQ-010 SHALL have port tick  output  1  one-cycle step strobe (debug).

Function
REQ-011 Prescaler: DIV_W-bit counter increments every cycle; tick=1 for exactly the cycle the counter is all-ones; counter wraps to 0.
REQ-012 All outputs registered; pattern updates on the clk edge where tick=1 (visible the cycle after tick).
REQ-013 FSM states: SCAN_R, SCAN_L, FILL, BLINK; mode=0 in SCAN_R/SCAN_L.
REQ-014 SCAN_R: red shifts right one bit per tick, E0->70->38->1C->0E->07; green=00.
REQ-015 SCAN_R with red=07, on tick: red=00, green=0E, go SCAN_L.
REQ-016 SCAN_L: green shifts left one bit per tick up to E0; red=00.
REQ-017 SCAN_L with green=E0, on tick: green=00, red=70, go SCAN_R; full cycle = 10 ticks.
REQ-018 FILL: green=00; red sequence 80,C0,E0,F0,F8,FC,FE,FF,00, then 80; period 9 ticks.
REQ-019 BLINK: alternates red=FF/green=00 and red=00/green=FF each tick.
REQ-020 Exactly one of shift_red/shift_green nonzero in SCAN; never both nonzero in any mode.
REQ-021 mode_next: next edge moves SCAN->FILL->BLINK->SCAN, loads the mode's initial pattern (SCAN: red=E0 in SCAN_R; FILL: red=80; BLINK: red=FF, green=00), clears prescaler.
REQ-022 mode_next and tick in same cycle: mode_next wins; the tick step is discarded.
REQ-023 Unreachable FSM encodings SHALL recover to SCAN_R, red=E0, green=00 on the next edge.

Reset
REQ-024 reset=1 at an edge: state SCAN_R, mode=0, shift_red=E0, shift_green=00, prescaler=0, tick=0; ctl_bit=1 always.
REQ-025 reset takes priority over mode_next, pause and tick; mid-sequence reset restarts SCAN from E0.

Configuration
REQ-026 Macro LED_SHOW_PAUSE_EN: when defined, pause port exists; pause=1 holds prescaler, tick=0, pattern and state; mode_next still honored; release resumes from held count.
REQ-027 When undefined: no pause port; prescaler and pattern never freeze.

Structure
REQ-028 Shared package led_show_pkg SHALL hold FSM state encoding, mode codes, and per-mode initial-pattern constants.
REQ-029 Prescaler SHALL be sub-module led_tick_gen (params DIV_W; ports clk, reset, clr, hold, tick).

Verification (DIV_W=2, tick every 4 cycles)
REQ-030 Reset 3 cycles, release -> shift_red=E0, green=00, mode=0, tick first at cycle 4 after release.
REQ-031 Run 10 ticks from reset -> red E0..07, green 0E..E0, then red=70 on tick 11.
REQ-032 mode_next pulse -> next cycle mode=1, red=80; 9 ticks later red back to 80 via FF, 00.
REQ-033 mode_next coincident with tick in BLINK -> mode=0, red=E0, no extra step, prescaler=0.
REQ-034 Reset asserted mid-FILL (red=F0) -> next edge red=E0, mode=0.
REQ-035 LED_SHOW_PAUSE_EN: pause high 20 cycles in SCAN -> no tick, pattern unchanged; mode_next during pause -> mode advances.
